// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational alu between two
// requesters, holding its inputs for EXEC_CYCLES and routing the result back.
module alu_arbiter #(
  parameter int WIDTH       = 8,
  parameter int SEL_W       = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [SEL_W-1:0] r0_sel,
  output logic             r0_resp_valid,
  output logic [WIDTH-1:0] r0_result,
  output logic             r0_carry,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [SEL_W-1:0] r1_sel,
  output logic             r1_resp_valid,
  output logic [WIDTH-1:0] r1_result,
  output logic             r1_carry,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SEL_W-1:0] sel;
  } op_t;

  localparam logic [3:0] LP_LAST = 4'(EXEC_CYCLES - 1);

  state_t           r_state;
  logic             r_last;
  logic             r_owner;
  logic [3:0]       r_cnt;
  op_t              r_op;
  logic [WIDTH-1:0] r_res0;
  logic [WIDTH-1:0] r_res1;
  logic             r_car0;
  logic             r_car1;
  logic             r_rv0;
  logic             r_rv1;
  logic             r_busy;

  logic w_idle;
  logic w_gnt0;
  logic w_gnt1;
  logic w_acc0;
  logic w_acc1;
  op_t  w_op0;
  op_t  w_op1;
  op_t  w_op;

  assign w_idle = (r_state == S_IDLE);
  assign w_op0  = {r0_a, r0_b, r0_sel};
  assign w_op1  = {r1_a, r1_b, r1_sel};

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    unique case (1'b1)
      (r0_valid && r1_valid): begin
        w_gnt0 = r_last;
        w_gnt1 = !r_last;
      end
      (r0_valid && !r1_valid): w_gnt0 = 1'b1;
      (!r0_valid && r1_valid): w_gnt1 = 1'b1;
      default: ;
    endcase
  end

  assign r0_ready = w_idle && w_gnt0 && !rst;
  assign r1_ready = w_idle && w_gnt1 && !rst;
  assign w_acc0   = r0_valid && r0_ready;
  assign w_acc1   = r1_valid && r1_ready;
  assign w_op     = w_acc1 ? w_op1 : w_op0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_cnt   <= '0;
      r_op    <= '0;
      r_res0  <= '0;
      r_res1  <= '0;
      r_car0  <= 1'b0;
      r_car1  <= 1'b0;
      r_rv0   <= 1'b0;
      r_rv1   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_rv0 <= 1'b0;
      r_rv1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc0 || w_acc1) begin
            r_op    <= w_op;
            r_owner <= w_acc1;
            r_last  <= w_acc1;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt == LP_LAST) begin
            // Capture into the owner only; the other side keeps its value.
            if (r_owner) begin
              r_res1 <= alu_result;
              r_car1 <= alu_carry;
              r_rv1  <= 1'b1;
            end else begin
              r_res0 <= alu_result;
              r_car0 <= alu_carry;
              r_rv0  <= 1'b1;
            end
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign alu_a         = r_op.a;
  assign alu_b         = r_op.b;
  assign alu_sel       = r_op.sel;
  assign r0_result     = r_res0;
  assign r0_carry      = r_car0;
  assign r0_resp_valid = r_rv0;
  assign r1_result     = r_res1;
  assign r1_carry      = r_car1;
  assign r1_resp_valid = r_rv1;
  assign busy          = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a randomized run
// checked against a cycle-level transaction model.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         checks = 0;
  int         errors = 0;

  logic       r0_valid = 1'b0, r1_valid = 1'b0;
  logic       r0_ready, r1_ready;
  logic [7:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
  logic [3:0] r0_sel = '0, r1_sel = '0;
  logic       r0_resp_valid, r1_resp_valid;
  logic [7:0] r0_result, r1_result;
  logic       r0_carry, r1_carry;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_sel;
  logic       alu_carry, busy;

  logic       q_r0_valid = 1'b0, q_r1_valid = 1'b0;
  logic       q_r0_ready, q_r1_ready;
  logic [7:0] q_r0_a = '0, q_r0_b = '0, q_r1_a = '0, q_r1_b = '0;
  logic [3:0] q_r0_sel = '0, q_r1_sel = '0;
  logic       q_r0_resp_valid, q_r1_resp_valid;
  logic [7:0] q_r0_result, q_r1_result;
  logic       q_r0_carry, q_r1_carry;
  logic [7:0] q_alu_a, q_alu_b, q_alu_result;
  logic [3:0] q_alu_sel;
  logic       q_alu_carry, q_busy;

  always #5 clk = ~clk;

  // Stand-in for the shared alu: {CarryOut, ALU_Out}.
  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] s);
    logic [7:0] y;
    logic [8:0] t;
    t = {1'b0, a} + {1'b0, b};
    case (s)
      4'h0: y = a + b;
      4'h1: y = a - b;
      4'h2: y = a * b;
      4'h3: y = (b == 8'h00) ? 8'h00 : a / b;
      4'h4: y = a << 1;
      4'h5: y = a >> 1;
      4'h6: y = {a[6:0], a[7]};
      4'h7: y = {a[0], a[7:1]};
      4'h8: y = a & b;
      4'h9: y = a | b;
      4'hA: y = a ^ b;
      4'hB: y = ~(a | b);
      4'hC: y = ~(a & b);
      4'hD: y = ~(a ^ b);
      4'hE: y = (a > b) ? 8'h01 : 8'h00;
      default: y = (a == b) ? 8'h01 : 8'h00;
    endcase
    return {t[8], y};
  endfunction

  always_comb {alu_carry, alu_result} = alu_ref(alu_a, alu_b, alu_sel);
  always_comb {q_alu_carry, q_alu_result} = alu_ref(q_alu_a, q_alu_b, q_alu_sel);

  alu_arbiter #(.WIDTH(8), .SEL_W(4), .EXEC_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r0_sel(r0_sel), .r0_resp_valid(r0_resp_valid), .r0_result(r0_result),
    .r0_carry(r0_carry),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
    .r1_sel(r1_sel), .r1_resp_valid(r1_resp_valid), .r1_result(r1_result),
    .r1_carry(r1_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carry(alu_carry), .busy(busy)
  );

  alu_arbiter #(.WIDTH(8), .SEL_W(4), .EXEC_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst),
    .r0_valid(q_r0_valid), .r0_ready(q_r0_ready), .r0_a(q_r0_a), .r0_b(q_r0_b),
    .r0_sel(q_r0_sel), .r0_resp_valid(q_r0_resp_valid), .r0_result(q_r0_result),
    .r0_carry(q_r0_carry),
    .r1_valid(q_r1_valid), .r1_ready(q_r1_ready), .r1_a(q_r1_a), .r1_b(q_r1_b),
    .r1_sel(q_r1_sel), .r1_resp_valid(q_r1_resp_valid), .r1_result(q_r1_result),
    .r1_carry(q_r1_carry),
    .alu_a(q_alu_a), .alu_b(q_alu_b), .alu_sel(q_alu_sel),
    .alu_result(q_alu_result), .alu_carry(q_alu_carry), .busy(q_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for accept, then observe 8 cycles.
  task automatic run_op(input int who, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] s, output int waited, output int lat,
                        output int own, output int oth, output bit stable);
    waited = 0; lat = -1; own = 0; oth = 0; stable = 1'b1;
    if (who == 0) begin
      r0_a = a; r0_b = b; r0_sel = s; r0_valid = 1'b1;
    end else begin
      r1_a = a; r1_b = b; r1_sel = s; r1_valid = 1'b1;
    end
    #1;
    while (!(who == 0 ? r0_ready : r1_ready) && waited < 10) begin
      tick;
      waited++;
    end
    tick;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (alu_a !== a || alu_b !== b || alu_sel !== s) stable = 1'b0;
      if (who == 0) begin
        own += int'(r0_resp_valid); oth += int'(r1_resp_valid);
        if (r0_resp_valid && lat < 0) lat = k;
      end else begin
        own += int'(r1_resp_valid); oth += int'(r0_resp_valid);
        if (r1_resp_valid && lat < 0) lat = k;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    tick;
    tick;
    checks++;
    if ({alu_a, alu_b, alu_sel, r0_result, r0_carry, r0_resp_valid, r1_result,
         r1_carry, r1_resp_valid, busy, r0_ready, r1_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got a=%h b=%h s=%h r0=%h r1=%h busy=%b rdy=%b%b exp all 0",
               alu_a, alu_b, alu_sel, r0_result, r1_result, busy, r0_ready, r1_ready);
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_single_r0;
    int w, lat, own, oth;
    bit st;
    run_op(0, 8'h0A, 8'h02, 4'h0, w, lat, own, oth, st);
    checks++;
    if (w !== 0) begin errors++; $display("FAIL single_wait got %0d exp 0", w); end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL single_latency got %0d exp 2", lat); end
    checks++;
    if (own !== 1 || oth !== 0) begin
      errors++; $display("FAIL single_pulses got own=%0d oth=%0d exp 1/0", own, oth);
    end
    checks++;
    if (r0_result !== 8'h0C || r0_carry !== 1'b0) begin
      errors++; $display("FAIL single_result got %h/%b exp 0c/0", r0_result, r0_carry);
    end
  endtask

  task automatic test_carry_r1;
    int w, lat, own, oth;
    bit st;
    run_op(1, 8'hF6, 8'h0A, 4'h0, w, lat, own, oth, st);
    checks++;
    if (lat !== 2 || own !== 1 || oth !== 0) begin
      errors++; $display("FAIL carry_pulse got lat=%0d own=%0d oth=%0d exp 2/1/0", lat, own, oth);
    end
    checks++;
    if (r1_result !== 8'h00 || r1_carry !== 1'b1) begin
      errors++; $display("FAIL carry_result got %h/%b exp 00/1", r1_result, r1_carry);
    end
    checks++;
    if (r0_result !== 8'h0C || r0_carry !== 1'b0) begin
      errors++; $display("FAIL carry_r0_held got %h/%b exp 0c/0", r0_result, r0_carry);
    end
  endtask

  task automatic test_sweep;
    int w, lat, own, oth;
    bit st;
    logic [8:0] e;
    for (int s = 0; s < 16; s++) begin
      e = alu_ref(8'h0A, 8'h02, 4'(s));
      run_op(0, 8'h0A, 8'h02, 4'(s), w, lat, own, oth, st);
      checks++;
      if (r0_result !== e[7:0] || r0_carry !== e[8] || lat !== 2) begin
        errors++;
        $display("FAIL sweep_sel%0d got %h/%b lat %0d exp %h/%b lat 2",
                 s, r0_result, r0_carry, lat, e[7:0], e[8]);
      end
      checks++;
      if (!st) begin errors++; $display("FAIL sweep_stable sel%0d got 0 exp 1", s); end
    end
  endtask

  task automatic test_contention;
    int g[$], gc[$], own[$];
    int both, nresp, eo;
    bit stop, ok;
    rst = 1'b1;
    r0_a = 8'h0A; r0_b = 8'h02; r0_sel = 4'h0;
    r1_a = 8'h05; r1_b = 8'h03; r1_sel = 4'h0;
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    both = 0; nresp = 0; stop = 1'b0;
    for (int c = 0; c < 40 && nresp < 4; c++) begin
      if (r0_ready && r1_ready) both++;
      if (r0_resp_valid || r1_resp_valid) begin
        eo = (own.size() > 0) ? own.pop_front() : -1;
        if (r0_resp_valid)
          ok = (eo == 0) && !r1_resp_valid && r0_result === 8'h0C;
        else
          ok = (eo == 1) && r1_result === 8'h08;
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL contention_resp%0d got rv=%b%b r0=%h r1=%h exp owner %0d",
                   nresp, r0_resp_valid, r1_resp_valid, r0_result, r1_result, eo);
        end
        nresp++;
      end
      if (!stop && (r0_ready || r1_ready)) begin
        g.push_back(r1_ready ? 1 : 0);
        own.push_back(r1_ready ? 1 : 0);
        gc.push_back(c);
        if (g.size() == 4) stop = 1'b1;
      end
      tick;
      if (stop) begin r0_valid = 1'b0; r1_valid = 1'b0; end
    end
    checks++;
    if (both !== 0) begin errors++; $display("FAIL contention_both_ready got %0d exp 0", both); end
    checks++;
    if (g.size() !== 4 || nresp !== 4) begin
      errors++; $display("FAIL contention_count got %0d/%0d exp 4/4", g.size(), nresp);
    end
    for (int i = 0; i < g.size(); i++) begin
      checks++;
      if (g[i] !== i % 2) begin
        errors++; $display("FAIL contention_grant%0d got %0d exp %0d", i, g[i], i % 2);
      end
      if (i > 0) begin
        checks++;
        if (gc[i] - gc[i-1] !== 3) begin
          errors++; $display("FAIL contention_gap%0d got %0d exp 3", i, gc[i] - gc[i-1]);
        end
      end
    end
    tick;
  endtask

  task automatic test_reset_mid;
    r0_a = 8'h33; r0_b = 8'h11; r0_sel = 4'h1; r0_valid = 1'b1;
    #1;
    checks++;
    if (r0_ready !== 1'b1) begin errors++; $display("FAIL midrst_accept got %b exp 1", r0_ready); end
    tick;
    r0_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy got %b exp 1", busy); end
    rst = 1'b1;
    tick;
    checks++;
    if ({alu_a, alu_b, alu_sel, r0_result, r0_carry, r0_resp_valid, r1_result,
         r1_carry, r1_resp_valid, busy, r0_ready, r1_ready} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got a=%h rv=%b r0=%h busy=%b exp all 0",
               alu_a, r0_resp_valid, r0_result, busy);
    end
    r0_a = 8'h0A; r0_b = 8'h02; r0_sel = 4'h0; r0_valid = 1'b1;
    tick;
    checks++;
    if (r0_resp_valid !== 1'b0 || r0_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_held got rv=%b rdy=%b exp 0/0", r0_resp_valid, r0_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (r0_ready !== 1'b1) begin errors++; $display("FAIL midrst_first_idle got %b exp 1", r0_ready); end
    tick;
    r0_valid = 1'b0;
    tick;
    checks++;
    if (r0_resp_valid !== 1'b1 || r0_result !== 8'h0C) begin
      errors++; $display("FAIL midrst_next_op got %b/%h exp 1/0c", r0_resp_valid, r0_result);
    end
    tick;
  endtask

  task automatic test_exec4;
    int acc[$], rsp[$];
    int unstable, held;
    unstable = 0; held = 0;
    q_r0_a = 8'h21; q_r0_b = 8'h13; q_r0_sel = 4'h1; q_r0_valid = 1'b1;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (q_r0_resp_valid) rsp.push_back(c);
      if (acc.size() == 1) begin
        held++;
        if (q_alu_a !== 8'h21 || q_alu_b !== 8'h13 || q_alu_sel !== 4'h1) unstable++;
      end
      if (q_r0_ready) acc.push_back(c);
      tick;
      if (acc.size() == 1 && acc[0] == c) begin
        q_r0_a = 8'h40; q_r0_b = 8'h05; q_r0_sel = 4'h0;
      end
      if (acc.size() == 2) q_r0_valid = 1'b0;
    end
    checks++;
    if (acc.size() !== 2 || rsp.size() !== 2) begin
      errors++; $display("FAIL exec4_count got %0d/%0d exp 2/2", acc.size(), rsp.size());
    end else begin
      checks++;
      if (acc[1] - acc[0] !== 6) begin
        errors++; $display("FAIL exec4_b2b got %0d exp 6", acc[1] - acc[0]);
      end
      checks++;
      if (rsp[0] - acc[0] !== 5 || rsp[1] - acc[1] !== 5) begin
        errors++;
        $display("FAIL exec4_latency got %0d/%0d exp 5/5", rsp[0] - acc[0], rsp[1] - acc[1]);
      end
    end
    checks++;
    if (unstable !== 0 || held < 4) begin
      errors++; $display("FAIL exec4_stable got unstable=%0d held=%0d exp 0/>=4", unstable, held);
    end
    checks++;
    if (q_r0_result !== 8'h45 || q_r0_carry !== 1'b0) begin
      errors++; $display("FAIL exec4_result got %h/%b exp 45/0", q_r0_result, q_r0_carry);
    end
  endtask

  // Transaction model: a request set is served when the unit is free;
  // ties go to the side that did not win last; a result appears E+1
  // cycles after its accept and the unit frees up one cycle later.
  task automatic test_random;
    int nf, due, due_own, g;
    logic [8:0] due_v;
    logic [7:0] mres[2];
    logic mcar[2];
    bit p0, p1, last;
    nf = 0; due = -1; due_own = 0; due_v = '0;
    mres[0] = '0; mres[1] = '0; mcar[0] = 1'b0; mcar[1] = 1'b0;
    p0 = 1'b0; p1 = 1'b0; last = 1'b1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int c = 0; c < 150; c++) begin
      if (!p0 && $urandom_range(0, 2) == 0) begin
        p0 = 1'b1; r0_a = 8'($urandom); r0_b = 8'($urandom); r0_sel = 4'($urandom);
      end
      if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1'b1; r1_a = 8'($urandom); r1_b = 8'($urandom); r1_sel = 4'($urandom);
      end
      r0_valid = p0;
      r1_valid = p1;
      #1;
      if (c == due) begin
        mres[due_own] = due_v[7:0];
        mcar[due_own] = due_v[8];
      end
      checks++;
      if (r0_resp_valid !== (c == due && due_own == 0) ||
          r1_resp_valid !== (c == due && due_own == 1)) begin
        errors++; $display("FAIL rand_resp c%0d got %b%b", c, r0_resp_valid, r1_resp_valid);
      end
      checks++;
      if (r0_result !== mres[0] || r0_carry !== mcar[0] ||
          r1_result !== mres[1] || r1_carry !== mcar[1]) begin
        errors++;
        $display("FAIL rand_result c%0d got %h/%b %h/%b exp %h/%b %h/%b", c, r0_result,
                 r0_carry, r1_result, r1_carry, mres[0], mcar[0], mres[1], mcar[1]);
      end
      checks++;
      if (busy !== (c < nf)) begin
        errors++; $display("FAIL rand_busy c%0d got %b exp %b", c, busy, c < nf);
      end
      g = -1;
      if (c >= nf && (p0 || p1)) g = (p0 && p1) ? (last ? 0 : 1) : (p0 ? 0 : 1);
      checks++;
      if (r0_ready !== (g == 0) || r1_ready !== (g == 1)) begin
        errors++; $display("FAIL rand_grant c%0d got %b%b exp grant %0d", c, r0_ready, r1_ready, g);
      end
      if (g >= 0) begin
        last = (g == 1);
        nf = c + 3;
        due = c + 2;
        due_own = g;
        due_v = (g == 1) ? alu_ref(r1_a, r1_b, r1_sel) : alu_ref(r0_a, r0_b, r0_sel);
      end
      tick;
      if (g == 0) p0 = 1'b0;
      if (g == 1) p1 = 1'b0;
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single_r0;
    test_carry_r1;
    test_sweep;
    test_contention;
    test_reset_mid;
    test_exec4;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
